// File: rtl/jtag_scan_driver.sv
// JTAG scan master: runs one IR scan then one DR scan per Start request,
// drives registered TMS/TDI, captures TDO into IR_Out/DR_Out.
// Ports: TCLK, RstBar (async low); Start, Instr, DR_In, TDO_In in;
//   TMS, TDI, Busy, Done, IR_Out, DR_Out out.
// Option: JTAG_SCAN_DRV_TLR_PREAMBLE_EN adds a 5-edge TMS=1 preamble
//   so every scan starts from Test-Logic-Reset.
module jtag_scan_driver #(
  parameter int IR_W = 3,
  parameter int DR_W = 20
) (
  input  logic            TCLK,
  input  logic            RstBar,
  input  logic            Start,
  input  logic [IR_W-1:0] Instr,
  input  logic [DR_W-1:0] DR_In,
  input  logic            TDO_In,
  output logic            TMS,
  output logic            TDI,
  output logic            Busy,
  output logic            Done,
  output logic [IR_W-1:0] IR_Out,
  output logic [DR_W-1:0] DR_Out
);

  localparam int MAXW = (IR_W > DR_W) ? IR_W : DR_W;
`ifdef JTAG_SCAN_DRV_TLR_PREAMBLE_EN
  localparam int CNTMAX = (MAXW > 5) ? MAXW : 5;
`else
  localparam int CNTMAX = MAXW;
`endif
  localparam int CW = $clog2(CNTMAX + 1);
  localparam logic [CW-1:0] IR_LAST = CW'(IR_W - 1);
  localparam logic [CW-1:0] DR_LAST = CW'(DR_W - 1);
`ifdef JTAG_SCAN_DRV_TLR_PREAMBLE_EN
  localparam logic [CW-1:0] PRE_LAST = CW'(4);
`endif

  // Each state names the TAP state the currently presented TMS
  // value moves the target into on the next rising edge.
  typedef enum logic [3:0] {
    IDLE, PRE, ENTRY, SEL_DR1, SEL_IR, CAP_IR,
    SHIFT_IR, EXIT1_IR, UPD_IR, SEL_DR2, CAP_DR,
    SHIFT_DR, EXIT1_DR, UPD_DR, DONE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            tlr, tlr_n;
  logic [IR_W-1:0] instr_q;
  logic [DR_W-1:0] dr_q;
  logic            sh_ir, sh_dr;
  logic            tms_n, tdi_n;
  logic            ir_bit, dr_bit;
  logic            start_acc;

  assign start_acc = (state == IDLE) && Start;

  always_comb begin
    ir_bit = 1'b0;
    for (int i = 0; i < IR_W; i++)
      if (cnt == CW'(i)) ir_bit = instr_q[i];
    dr_bit = 1'b0;
    for (int i = 0; i < DR_W; i++)
      if (cnt == CW'(i)) dr_bit = dr_q[i];
  end

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    tdi_n   = 1'b0;
    tlr_n   = tlr && !start_acc;
    unique case (state)
      IDLE: begin
        if (Start) begin
`ifdef JTAG_SCAN_DRV_TLR_PREAMBLE_EN
          state_n = PRE;
`else
          state_n = tlr ? ENTRY : SEL_DR1;
`endif
        end
      end
`ifdef JTAG_SCAN_DRV_TLR_PREAMBLE_EN
      PRE: begin
        if (cnt == PRE_LAST) state_n = ENTRY;
        else cnt_n = cnt + CW'(1);
      end
`endif
      ENTRY:    state_n = SEL_DR1;
      SEL_DR1:  state_n = SEL_IR;
      SEL_IR:   state_n = CAP_IR;
      CAP_IR:   state_n = SHIFT_IR;
      // Value presented after SHIFT_IR count c is consumed on shift
      // edge c, so the bit at index cnt goes out next.
      SHIFT_IR: begin
        tdi_n = ir_bit;
        if (cnt == IR_LAST) state_n = EXIT1_IR;
        else cnt_n = cnt + CW'(1);
      end
      EXIT1_IR: state_n = UPD_IR;
      UPD_IR:   state_n = SEL_DR2;
      SEL_DR2:  state_n = CAP_DR;
      CAP_DR:   state_n = SHIFT_DR;
      SHIFT_DR: begin
        tdi_n = dr_bit;
        if (cnt == DR_LAST) state_n = EXIT1_DR;
        else cnt_n = cnt + CW'(1);
      end
      EXIT1_DR: state_n = UPD_DR;
      UPD_DR:   state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase

    case (state_n)
      PRE, SEL_DR1, SEL_IR, EXIT1_IR,
      UPD_IR, SEL_DR2, EXIT1_DR, UPD_DR: tms_n = 1'b1;
      IDLE:    tms_n = tlr_n;
      default: tms_n = 1'b0;
    endcase
  end

  always_ff @(posedge TCLK or negedge RstBar) begin
    if (!RstBar) begin
      state   <= IDLE;
      cnt     <= '0;
      tlr     <= 1'b1;
      instr_q <= '0;
      dr_q    <= '0;
      sh_ir   <= 1'b0;
      sh_dr   <= 1'b0;
      TMS     <= 1'b1;
      TDI     <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      IR_Out  <= '0;
      DR_Out  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      tlr   <= tlr_n;
      TMS   <= tms_n;
      TDI   <= tdi_n;
      Busy  <= (state_n != IDLE);
      Done  <= (state == DONE);
      // Target is in Shift-xR on the edge after one that entered it.
      sh_ir <= (state == SHIFT_IR);
      sh_dr <= (state == SHIFT_DR);
      if (start_acc) begin
        instr_q <= Instr;
        dr_q    <= DR_In;
      end
      if (sh_ir)
        IR_Out <= (IR_Out >> 1) |
                  (IR_W'(TDO_In) << (IR_W - 1));
      if (sh_dr)
        DR_Out <= (DR_Out >> 1) |
                  (DR_W'(TDO_In) << (DR_W - 1));
    end
  end

endmodule
